wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_pkg.sv | 32 +++
 rtl/wb_fifo.sv | 69 ++++++
 rtl/wb_stage.sv | 146 ++++++++++++++
 tb/tb_wb_stage.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg -- shared types and constants for the write-back stage.
//   wb_entry_t    : one queued register-file write {dest, simd, data}
//   reg_pair_mask : one-hot mask of the register(s) touched by a write
//                   (a SIMD write to register d also covers (d+1) mod 16)
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam int REG_W    = 28;
    localparam int NUM_REGS = 16;
    localparam int DEST_W   = 4;
    localparam int DATA_W   = 2 * REG_W;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic              simd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // SIMD destinations cover a register pair; dest 15 wraps to {15, 0}
    // through the natural 4-bit overflow of w_next.
    function automatic logic [NUM_REGS-1:0] reg_pair_mask(
        input logic [DEST_W-1:0] dest,
        input logic              simd
    );
        logic [DEST_W-1:0] w_next;
        w_next = dest + 4'd1;
        return (NUM_REGS'(1) << dest) |
               (simd ? (NUM_REGS'(1) << w_next) : {NUM_REGS{1'b0}});
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo -- in-order synchronous FIFO of wb_entry_t results.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   i_push        : write i_push_data (ignored when full)
//   i_pop         : retire the head entry (ignored when empty)
//   o_head        : current head entry (valid when !o_empty)
//   o_full/o_empty: occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      i_push,
    input  wb_entry_t i_push_data,
    input  logic      i_pop,
    output wb_entry_t o_head,
    output logic      o_full,
    output logic      o_empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      r_mem [DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           w_push;
    logic           w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == {(AW+1){1'b0}});
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    // Storage array: written on accepted push, no reset needed (guarded by count).
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage -- write-back stage: arbitrates ALU/MEM results (MEM has priority),
// queues them in order, drives one register-file write per cycle, and keeps a
// pending-write scoreboard.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   alu_valid/ready/dest/simd/data   : ALU result producer (valid/ready)
//   mem_valid/ready/dest/simd/data   : MEM result producer (valid/ready)
//   claim_en/claim_dest/claim_simd   : issue-time claim of a destination
//   busy_mask                        : pending-write bit per register
//   rf_wen/rf_iswrSIMD/rf_dest_sel/rf_data : registered RF write port
// Build option: define WB_BYPASS_EN to let a result accepted into an empty
// queue load the RF write registers directly (latency 1 instead of 2).
// -----------------------------------------------------------------------------
module wb_stage
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int REG_W = 28
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    output logic                 alu_ready,
    input  logic [3:0]           alu_dest,
    input  logic                 alu_simd,
    input  logic [2*REG_W-1:0]   alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [3:0]           mem_dest,
    input  logic                 mem_simd,
    input  logic [2*REG_W-1:0]   mem_data,
    input  logic                 claim_en,
    input  logic [3:0]           claim_dest,
    input  logic                 claim_simd,
    output logic [15:0]          busy_mask,
    output logic                 rf_wen,
    output logic                 rf_iswrSIMD,
    output logic [3:0]           rf_dest_sel,
    output logic [2*REG_W-1:0]   rf_data
);

    wb_entry_t             w_push_entry;
    wb_entry_t             w_head;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_mem_xfer;
    logic                  w_alu_xfer;
    logic                  w_accept;
    logic                  w_bypass;
    logic                  w_fifo_push;
    logic                  w_pop;
    logic [NUM_REGS-1:0]   w_set;
    logic [NUM_REGS-1:0]   w_clr;

    logic                  r_rf_wen;
    logic                  r_rf_iswrSIMD;
    logic [DEST_W-1:0]     r_rf_dest_sel;
    logic [2*REG_W-1:0]    r_rf_data;
    logic [NUM_REGS-1:0]   r_busy;

    // Only one result per cycle; MEM wins so ALU is held off whenever MEM is valid.
    assign mem_ready  = !w_full;
    assign alu_ready  = !w_full && !mem_valid;
    assign w_mem_xfer = mem_valid && mem_ready;
    assign w_alu_xfer = alu_valid && alu_ready;
    assign w_accept   = (w_mem_xfer || w_alu_xfer) && !rst;
    assign w_pop      = !w_empty && !rst;

`ifdef WB_BYPASS_EN
    // An empty queue cannot pop this cycle, so the result may skip the queue.
    assign w_bypass = w_accept && w_empty;
`else
    assign w_bypass = 1'b0;
`endif
    assign w_fifo_push = w_accept && !w_bypass;

    // Select the accepted producer's payload.
    always_comb begin
        w_push_entry = '0;
        if (w_mem_xfer) begin
            w_push_entry.dest = mem_dest;
            w_push_entry.simd = mem_simd;
            w_push_entry.data = mem_data;
        end else begin
            w_push_entry.dest = alu_dest;
            w_push_entry.simd = alu_simd;
            w_push_entry.data = alu_data;
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_fifo_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // RF write registers: head (or bypassed result) loads with a one-cycle write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_wen      <= 1'b0;
            r_rf_iswrSIMD <= 1'b0;
            r_rf_dest_sel <= 4'd0;
            r_rf_data     <= '0;
        end else if (w_pop) begin
            r_rf_wen      <= 1'b1;
            r_rf_iswrSIMD <= w_head.simd;
            r_rf_dest_sel <= w_head.dest;
            r_rf_data     <= w_head.data;
        end else if (w_bypass) begin
            r_rf_wen      <= 1'b1;
            r_rf_iswrSIMD <= w_push_entry.simd;
            r_rf_dest_sel <= w_push_entry.dest;
            r_rf_data     <= w_push_entry.data;
        end else begin
            r_rf_wen      <= 1'b0;
        end
    end

    // The clear is applied in the cycle the write is presented to the RF.
    assign w_set = claim_en ? reg_pair_mask(claim_dest, claim_simd) : {NUM_REGS{1'b0}};
    assign w_clr = r_rf_wen ? reg_pair_mask(r_rf_dest_sel, r_rf_iswrSIMD) : {NUM_REGS{1'b0}};

    // Scoreboard: set after clear so a simultaneous claim of the same register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= {NUM_REGS{1'b0}};
        end else begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign busy_mask   = r_busy;
    assign rf_wen      = r_rf_wen;
    assign rf_iswrSIMD = r_rf_iswrSIMD;
    assign rf_dest_sel = r_rf_dest_sel;
    assign rf_data     = r_rf_data;

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage. A queue-based reference
// model tracks results waiting for write-back and the set of registers with a
// pending write; DUT outputs are compared every cycle.
// -----------------------------------------------------------------------------
module tb_wb_stage;
    import wb_pkg::*;

    localparam int DEPTH = 4;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, alu_simd;
    logic [3:0]  alu_dest;
    logic [55:0] alu_data;
    logic        mem_valid, mem_ready, mem_simd;
    logic [3:0]  mem_dest;
    logic [55:0] mem_data;
    logic        claim_en, claim_simd;
    logic [3:0]  claim_dest;
    logic [15:0] busy_mask;
    logic        rf_wen, rf_iswrSIMD;
    logic [3:0]  rf_dest_sel;
    logic [55:0] rf_data;

    always #5 clk = ~clk;

    wb_stage #(.DEPTH(DEPTH), .REG_W(28)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest),
        .alu_simd(alu_simd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest),
        .mem_simd(mem_simd), .mem_data(mem_data),
        .claim_en(claim_en), .claim_dest(claim_dest), .claim_simd(claim_simd),
        .busy_mask(busy_mask),
        .rf_wen(rf_wen), .rf_iswrSIMD(rf_iswrSIMD), .rf_dest_sel(rf_dest_sel),
        .rf_data(rf_data)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // ---------------- reference model ----------------
    wb_entry_t   waiting_q[$];   // accepted, not yet presented to the RF
    wb_entry_t   m_out;          // last write presented to the RF
    logic        m_wen;
    logic [15:0] m_busy;
    bit          g_mem_acc, g_alu_acc;

    function automatic logic [15:0] regs_of(input logic [3:0] d, input logic s);
        logic [15:0] m;
        m = 16'h0000;
        m[int'(d)] = 1'b1;
        if (s) m[(int'(d) + 1) % 16] = 1'b1;
        return m;
    endfunction

    function automatic logic [55:0] rnd56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[55:0];
    endfunction

    // One clock: check readys, advance model across the edge, check outputs.
    task automatic cycle();
        bit          full_m, have_acc;
        wb_entry_t   acc;
        logic [15:0] clr, set;
        #1;
        full_m = (waiting_q.size() == DEPTH);
        if (!rst) begin
            check_val("mem_ready", 64'(mem_ready), 64'(!full_m));
            check_val("alu_ready", 64'(alu_ready), 64'(!full_m && !mem_valid));
        end
        g_mem_acc = !rst && mem_valid && !full_m;
        g_alu_acc = !rst && alu_valid && !full_m && !mem_valid;
        have_acc  = g_mem_acc || g_alu_acc;
        acc.dest  = g_mem_acc ? mem_dest : alu_dest;
        acc.simd  = g_mem_acc ? mem_simd : alu_simd;
        acc.data  = g_mem_acc ? mem_data : alu_data;
        clr = m_wen ? regs_of(m_out.dest, m_out.simd) : 16'h0000;
        set = claim_en ? regs_of(claim_dest, claim_simd) : 16'h0000;
        @(posedge clk);
        if (rst) begin
            waiting_q.delete();
            m_wen  = 1'b0;
            m_out  = '0;
            m_busy = 16'h0000;
        end else begin
            m_busy = (m_busy & ~clr) | set;
            if (waiting_q.size() > 0) begin
                m_out = waiting_q.pop_front();
                m_wen = 1'b1;
            end else if (BYPASS && have_acc) begin
                m_out    = acc;
                m_wen    = 1'b1;
                have_acc = 1'b0;
            end else begin
                m_wen = 1'b0;
            end
            if (have_acc) waiting_q.push_back(acc);
        end
        @(negedge clk);
        check_val("rf_wen",      64'(rf_wen),      64'(m_wen));
        check_val("rf_dest_sel", 64'(rf_dest_sel), 64'(m_out.dest));
        check_val("rf_iswrSIMD", 64'(rf_iswrSIMD), 64'(m_out.simd));
        check_val("rf_data",     64'(rf_data),     64'(m_out.data));
        check_val("busy_mask",   64'(busy_mask),   64'(m_busy));
    endtask

    task automatic idle_inputs();
        rst = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; claim_en = 1'b0;
    endtask

    // Random producers honour the hold-until-transfer rule.
    task automatic gen(input int rate, input int claim_rate);
        if (!mem_valid || g_mem_acc) begin
            mem_valid = ($urandom_range(0, 99) < rate);
            mem_dest  = 4'($urandom());
            mem_simd  = 1'($urandom());
            mem_data  = rnd56();
        end
        if (!alu_valid || g_alu_acc) begin
            alu_valid = ($urandom_range(0, 99) < rate);
            alu_dest  = 4'($urandom());
            alu_simd  = 1'($urandom());
            alu_data  = rnd56();
        end
        claim_en   = ($urandom_range(0, 99) < claim_rate);
        claim_dest = 4'($urandom());
        claim_simd = 1'($urandom());
    endtask

    initial begin
        m_out = '0; m_wen = 1'b0; m_busy = 16'h0000;
        alu_dest = 4'd0; alu_simd = 1'b0; alu_data = 56'd0;
        mem_dest = 4'd0; mem_simd = 1'b0; mem_data = 56'd0;
        claim_dest = 4'd0; claim_simd = 1'b0;
        idle_inputs();

        // Reset, with a result and a claim presented during reset (must be dropped).
        rst = 1'b1; alu_valid = 1'b1; alu_dest = 4'd9; claim_en = 1'b1; claim_dest = 4'd9;
        cycle();
        cycle();
        idle_inputs();
        cycle();
        check_val("reset_ready", 64'({mem_ready, alu_ready}), 64'(2'b11));

        // Single ALU result to register 3.
        alu_valid = 1'b1; alu_dest = 4'd3; alu_simd = 1'b0; alu_data = 56'hABCDEF1_0000000;
        cycle();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();

        // MEM and ALU together: ALU is held off while MEM keeps presenting.
        alu_valid = 1'b1; alu_dest = 4'd1; alu_simd = 1'b0; alu_data = rnd56();
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_dest = 4'(8 + i); mem_simd = 1'b0; mem_data = rnd56();
            cycle();
        end
        mem_valid = 1'b0;
        cycle();
        alu_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // SIMD claim on register 15 wraps to {15,0}; matching write clears it.
        claim_en = 1'b1; claim_dest = 4'd15; claim_simd = 1'b1;
        cycle();
        claim_en = 1'b0;
        check_val("busy_8001", 64'(busy_mask), 64'(16'h8001));
        mem_valid = 1'b1; mem_dest = 4'd15; mem_simd = 1'b1; mem_data = rnd56();
        cycle();
        mem_valid = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check_val("busy_cleared", 64'(busy_mask), 64'(16'h0000));

        // Claim of register 5 in the same cycle its write is presented: set wins.
        claim_en = 1'b1; claim_dest = 4'd5; claim_simd = 1'b0;
        mem_valid = 1'b1; mem_dest = 4'd5; mem_simd = 1'b0; mem_data = rnd56();
        cycle();
        mem_valid = 1'b0; claim_en = 1'b0;
        if (BYPASS) begin
            claim_en = 1'b1;
            cycle();
        end else begin
            cycle();
            claim_en = 1'b1;
            cycle();
        end
        claim_en = 1'b0;
        cycle();
        check_val("busy5_set_wins", 64'(busy_mask[5]), 64'(1'b1));

        // Five back-to-back MEM results.
        for (int i = 0; i < 5; i++) begin
            mem_valid = 1'b1; mem_dest = 4'(i + 2); mem_simd = 1'(i); mem_data = rnd56();
            cycle();
        end
        mem_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();

        // Randomised traffic at several densities.
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 150; i++) begin
                gen(30 + 30 * r, 25);
                cycle();
            end
        end

        // Reset in the middle of traffic with registers 4..7 pending.
        idle_inputs();
        cycle();
        claim_en = 1'b1; claim_dest = 4'd4; claim_simd = 1'b1;
        cycle();
        claim_dest = 4'd6;
        cycle();
        claim_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gen(100, 0);
            cycle();
        end
        rst = 1'b1; mem_valid = 1'b1; alu_valid = 1'b1; claim_en = 1'b1;
        cycle();
        idle_inputs();
        check_val("rst_busy", 64'(busy_mask), 64'(16'h0000));
        check_val("rst_wen", 64'(rf_wen), 64'(1'b0));
        for (int i = 0; i < 5; i++) cycle();
        check_val("post_rst_ready", 64'({mem_ready, alu_ready}), 64'(2'b11));

        // More random traffic, then drain.
        for (int i = 0; i < 100; i++) begin
            gen(70, 30);
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 8; i++) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
